// File: rtl/xpb_accum_seq.sv
// ---------------------------------------------------------------------------
// xpb_accum_seq
//
// Sequences the time-multiplexed XPB table lookups used by the modular-square
// reduction. A request carries NUM_SEGS upper-product segments packed in one
// word. The block walks them one per cycle. For segment i it drives
// xpb_sel = i and xpb_idx = segment value to the shared table mux. It adds the
// table word that comes back in the same cycle into a wide accumulator. The
// finished sum goes to the reduction adder tree through a valid/ready
// handshake.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   in_ready is 1 only in IDLE.
//   out_valid is 1 only in DONE. While out_valid is high and out_ready is low,
//   out_sum holds its value.
//   The output transfer returns the block to IDLE. No new request is taken on
//   the same edge.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high; aborts any request in progress
//   in_valid   request valid
//   in_ready   block idle and able to take a request
//   in_upper   packed segments; segment i = in_upper[i*SEG_BITS +: SEG_BITS]
//   xpb_sel    table select (current segment number); 0 outside LOOKUP
//   xpb_idx    table address (current segment value); 0 outside LOOKUP
//   xpb_data   table output, combinational from xpb_sel/xpb_idx
//   out_valid  out_sum valid
//   out_ready  consumer accepts out_sum
//   out_sum    sum over i of table_i[segment_i]; 0 when not valid
//   busy       FSM is not in IDLE (also serves as the FSM debug view)
// ---------------------------------------------------------------------------
module xpb_accum_seq #(
    parameter int SEG_BITS = 5,
    parameter int NUM_SEGS = 4,
    parameter int XPB_W    = 1024,
    parameter int ACC_W    = 1028,
    localparam int SEL_W   = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
    localparam int UPPER_W = NUM_SEGS * SEG_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UPPER_W-1:0] in_upper,
    output logic [SEL_W-1:0]   xpb_sel,
    output logic [SEG_BITS-1:0] xpb_idx,
    input  logic [XPB_W-1:0]   xpb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               busy
);

    // Refuse to build a configuration whose accumulator could drop a carry.
    if (NUM_SEGS < 1) begin : g_bad_num_segs
        $error("xpb_accum_seq: NUM_SEGS must be at least 1");
    end
    if (ACC_W < XPB_W + $clog2(NUM_SEGS)) begin : g_bad_acc_w
        $error("xpb_accum_seq: ACC_W too small for XPB_W + clog2(NUM_SEGS)");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [SEL_W-1:0]     seg_q;
    logic [UPPER_W-1:0]   upper_q;
    logic [ACC_W-1:0]     acc_q;
    logic [SEG_BITS-1:0]  seg_val;
    logic                 last_seg;

    assign last_seg = (seg_q == SEL_W'(NUM_SEGS - 1));

    // Pick the captured segment addressed by the counter. An explicit compare
    // loop keeps the select in range even when SEL_W can count past NUM_SEGS-1.
    always_comb begin
        seg_val = '0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (seg_q == SEL_W'(i)) begin
                seg_val = upper_q[i*SEG_BITS +: SEG_BITS];
            end
        end
    end

    // FSM process 1: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM process 2: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LOOKUP;
            LOOKUP:  if (last_seg) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM process 3: outputs, decoded only from registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        xpb_sel   = '0;
        xpb_idx   = '0;
        out_sum   = '0;
        if (state_q == LOOKUP) begin
            xpb_sel = seg_q;
            xpb_idx = seg_val;
        end
        if (state_q == DONE) begin
            out_sum = acc_q;
        end
    end

    // Datapath: capture, segment walk and accumulation. Every segment uses its
    // cycle, including zero-valued ones, so latency does not depend on data.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q   <= '0;
            upper_q <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        upper_q <= in_upper;
                        acc_q   <= '0;
                        seg_q   <= '0;
                    end
                end
                LOOKUP: begin
                    acc_q <= acc_q + ACC_W'(xpb_data);
                    seg_q <= last_seg ? '0 : seg_q + SEL_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// ---------------------------------------------------------------------------
// Testbench for xpb_accum_seq.
//
// The table mux has two modes:
//   stub mode:  (sel+1)*idx
//   wide mode:  random 1024-bit words, with every entry at index 31 set to
//               all ones so the carries reach the top accumulator bits.
// Inputs change 2 time units after a rising edge. Outputs are sampled on the
// falling edge or at those same +2 points.
// ---------------------------------------------------------------------------
module tb_xpb_accum_seq;

    localparam int SEG_BITS = 5;
    localparam int NUM_SEGS = 4;
    localparam int XPB_W    = 1024;
    localparam int ACC_W    = 1028;
    localparam int SEL_W    = 2;
    localparam int UW       = NUM_SEGS * SEG_BITS;
    localparam int PW       = SEL_W + SEG_BITS;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [UW-1:0]     in_upper;
    logic [SEL_W-1:0]  xpb_sel;
    logic [SEG_BITS-1:0] xpb_idx;
    logic [XPB_W-1:0]  xpb_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xpb_accum_seq #(
        .SEG_BITS(SEG_BITS),
        .NUM_SEGS(NUM_SEGS),
        .XPB_W(XPB_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_upper(in_upper),
        .xpb_sel(xpb_sel),
        .xpb_idx(xpb_idx),
        .xpb_data(xpb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .busy(busy)
    );

    // ---------------- table stub ----------------
    bit               use_stub;
    logic [XPB_W-1:0] wide_tbl [NUM_SEGS][32];

    assign xpb_data = use_stub ? XPB_W'((int'(xpb_sel) + 1) * int'(xpb_idx))
                               : wide_tbl[xpb_sel][xpb_idx];

    function automatic logic [XPB_W-1:0] tbl(input int sel, input logic [SEG_BITS-1:0] idx);
        if (use_stub) return XPB_W'((sel + 1) * int'(idx));
        return wide_tbl[sel][idx];
    endfunction

    task automatic fill_wide();
        for (int s = 0; s < NUM_SEGS; s++) begin
            for (int a = 0; a < 32; a++) begin
                for (int w = 0; w < XPB_W / 32; w++) begin
                    wide_tbl[s][a][w*32 +: 32] = $urandom();
                end
            end
            wide_tbl[s][31] = '1;
        end
    endtask

    // ---------------- reference model ----------------
    // Sum of the table words picked by each segment, in plain wide arithmetic.
    function automatic logic [ACC_W-1:0] model_sum(input logic [UW-1:0] u);
        logic [ACC_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            s = s + ACC_W'(tbl(i, u[i*SEG_BITS +: SEG_BITS]));
        end
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_fail;

    task automatic check_val(input string tag, input logic [ACC_W-1:0] obs,
                             input logic [ACC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got hi=%0h lo=%0h, expected hi=%0h lo=%0h", tag,
                     obs[ACC_W-1:XPB_W], obs[63:0], exp[ACC_W-1:XPB_W], exp[63:0]);
        end
    endtask

    logic [ACC_W-1:0] exp_q[$];
    logic [PW-1:0]    exp_pair_q[$];
    int               lat_q[$];
    int               ncyc;
    int               last_accept_cyc;
    bit               prev_ov;

    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            exp_q.delete();
            exp_pair_q.delete();
            lat_q.delete();
            prev_ov = 1'b0;
        end else begin
            // Table select/address: walk order in LOOKUP, zero elsewhere.
            if (busy && !out_valid) begin
                if (exp_pair_q.size() == 0) begin
                    check_val("unexpected_lookup", ACC_W'(1), ACC_W'(0));
                end else begin
                    check_val("xpb_sel_idx", ACC_W'({xpb_sel, xpb_idx}),
                              ACC_W'(exp_pair_q.pop_front()));
                end
            end else begin
                check_val("xpb_sel_idx_zero", ACC_W'({xpb_sel, xpb_idx}), ACC_W'(0));
            end
            if (out_valid) check_val("in_ready_while_done", ACC_W'(in_ready), ACC_W'(0));
            // Latency from accept to first out_valid cycle.
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) begin
                    check_val("unexpected_out_valid", ACC_W'(1), ACC_W'(0));
                end else begin
                    check_val("latency", ACC_W'(ncyc - lat_q.pop_front()),
                              ACC_W'(NUM_SEGS + 1));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", ACC_W'(1), ACC_W'(0));
                end else begin
                    check_val("out_sum", out_sum, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_sum(in_upper));
                lat_q.push_back(ncyc);
                last_accept_cyc = ncyc;
                for (int i = 0; i < NUM_SEGS; i++) begin
                    exp_pair_q.push_back({SEL_W'(i), in_upper[i*SEG_BITS +: SEG_BITS]});
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [UW-1:0] u, input bit hold);
        int k;
        in_upper = u;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            step();
            k++;
        end
        check_val("accept", ACC_W'(in_ready), ACC_W'(1));
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            step();
            k++;
        end
        check_val("out_valid_wait", ACC_W'(out_valid), ACC_W'(1));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check_val("idle_wait", ACC_W'(busy), ACC_W'(0));
    endtask

    function automatic logic [UW-1:0] rand_upper();
        logic [UW-1:0] u;
        for (int i = 0; i < NUM_SEGS; i++) begin
            case ($urandom_range(0, 3))
                0:       u[i*SEG_BITS +: SEG_BITS] = '0;
                1:       u[i*SEG_BITS +: SEG_BITS] = '1;
                default: u[i*SEG_BITS +: SEG_BITS] = SEG_BITS'($urandom_range(0, 31));
            endcase
        end
        return u;
    endfunction

    task automatic run_random(input int n);
        int k;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 2)) step();
            send(rand_upper(), 1'b0);
            k = 0;
            while (busy && k < 100) begin
                out_ready = ($urandom_range(0, 3) != 0);
                step();
                k++;
            end
            check_val("rand_drain", ACC_W'(busy), ACC_W'(0));
            out_ready = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_in_ready"},  ACC_W'(in_ready),  ACC_W'(1));
        check_val({tag, "_out_valid"}, ACC_W'(out_valid), ACC_W'(0));
        check_val({tag, "_out_sum"},   out_sum,           ACC_W'(0));
        check_val({tag, "_busy"},      ACC_W'(busy),      ACC_W'(0));
        check_val({tag, "_sel_idx"},   ACC_W'({xpb_sel, xpb_idx}), ACC_W'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [ACC_W-1:0] held;
        logic [ACC_W-1:0] big;
        int               acc_t [3];

        n_checks = 0;
        n_fail   = 0;
        ncyc     = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_upper = '0;
        out_ready = 1'b1;
        use_stub = 1'b1;
        fill_wide();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        check_reset_values("reset");

        // Directed example: 1 + 0 + 3*2 + 4*31 = 131.
        send({5'd31, 5'd2, 5'd0, 5'd1}, 1'b0);
        wait_ov();
        check_val("directed_131", out_sum, ACC_W'(131));
        wait_idle();

        // All-zero segments: zero sum, same latency (checked by monitor).
        send('0, 1'b0);
        wait_ov();
        check_val("zero_sum", out_sum, ACC_W'(0));
        wait_idle();

        // Wide table, all segments 31: four all-ones words need 1026 bits.
        use_stub = 1'b0;
        send('1, 1'b0);
        wait_ov();
        big = (ACC_W'(1) << (XPB_W + 2)) - ACC_W'(4);
        check_val("wide_all_ones", out_sum, big);
        wait_idle();
        run_random(8);
        use_stub = 1'b1;

        // Backpressure: DONE holds for 10 cycles, in_valid pulses ignored.
        out_ready = 1'b0;
        send(rand_upper(), 1'b0);
        wait_ov();
        held = out_sum;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_upper = UW'($urandom());
            step();
            check_val("bp_out_valid", ACC_W'(out_valid), ACC_W'(1));
            check_val("bp_out_sum",   out_sum,           held);
            check_val("bp_in_ready",  ACC_W'(in_ready),  ACC_W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("bp_release_in_ready",  ACC_W'(in_ready),  ACC_W'(1));
        check_val("bp_release_out_valid", ACC_W'(out_valid), ACC_W'(0));

        // Back-to-back with in_valid held high: one accept every NUM_SEGS+2.
        for (int r = 0; r < 3; r++) begin
            send(rand_upper(), r < 2);
            acc_t[r] = last_accept_cyc;
        end
        check_val("b2b_gap1", ACC_W'(acc_t[1] - acc_t[0]), ACC_W'(NUM_SEGS + 2));
        check_val("b2b_gap2", ACC_W'(acc_t[2] - acc_t[1]), ACC_W'(NUM_SEGS + 2));
        wait_idle();

        // Reset during LOOKUP at segment 2, then a clean request.
        send({5'd7, 5'd9, 5'd11, 5'd13}, 1'b0);
        step();
        step();
        check_val("mid_lookup_sel", ACC_W'(xpb_sel), ACC_W'(2));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("mid_reset");
        send({5'd1, 5'd1, 5'd1, 5'd1}, 1'b0);
        wait_ov();
        check_val("after_reset_sum", out_sum, ACC_W'(10));
        wait_idle();

        // Reset while DONE is stalled with out_valid high.
        out_ready = 1'b0;
        send(rand_upper(), 1'b0);
        wait_ov();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("done_reset");
        out_ready = 1'b1;

        // Random traffic with random backpressure.
        run_random(12);

        repeat (4) step();
        check_val("exp_q_empty", ACC_W'(exp_q.size()), ACC_W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
